matmul_job_sequencer: RTL and testbench

- Per-job controller for the matrix-multiply subsystem; sits between the host command path and the SPI loader, multiply engine and SPI sender.
- Accepts one job at a time as an M/K/N command and validates the dimensions.
- Sequences the job: wait for the A and B loads, start the engine, wait for it to finish, then optionally start transmission of C.
- Reports completion or error with a per-phase watchdog timeout and host abort.

---
 rtl/matmul_job_sequencer.sv | 177 +++++++++++++++++
 tb/tb_matmul_job_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_sequencer.sv
// rtl/matmul_job_sequencer.sv - per-job sequencer: accept, validate, load, compute, send, report.
// A job command is accepted only in IDLE; each wait phase has its own watchdog.
module matmul_job_sequencer #(
  parameter  int MAX_M   = 784,
  parameter  int MAX_K   = 288,
  parameter  int MAX_N   = 64,
  parameter  int TIMEOUT = 1000000,
  localparam int MW      = $clog2(MAX_M) + 1,
  localparam int KW      = $clog2(MAX_K) + 1,
  localparam int NW      = $clog2(MAX_N) + 1,
  localparam int TW      = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [MW-1:0] cmd_m,
  input  logic [KW-1:0] cmd_k,
  input  logic [NW-1:0] cmd_n,
  input  logic          cmd_send,
  input  logic          abort,
  input  logic          a_ready,
  input  logic          b_ready,
  output logic          eng_start,
  input  logic          eng_done,
  output logic [MW-1:0] eng_m,
  output logic [KW-1:0] eng_k,
  output logic [NW-1:0] eng_n,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy,
  output logic          job_done,
  output logic          job_err,
  output logic [1:0]    err_code,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_SEND    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  state_e        state_q;
  logic [MW-1:0] eng_m_q;
  logic [KW-1:0] eng_k_q;
  logic [NW-1:0] eng_n_q;
  logic          send_q;
  logic [TW-1:0] wd_q;
  logic          eng_start_q;
  logic          tx_start_q;
  logic          job_done_q;
  logic          job_err_q;
  logic [1:0]    err_code_q;

  logic wd_last;
  logic dims_bad;

  assign wd_last  = (wd_q == TW'(TIMEOUT - 1));
  assign dims_bad = (eng_m_q == '0) || (eng_k_q == '0) || (eng_n_q == '0) ||
                    (eng_m_q > MW'(MAX_M)) || (eng_k_q > KW'(MAX_K)) ||
                    (eng_n_q > NW'(MAX_N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      eng_m_q     <= '0;
      eng_k_q     <= '0;
      eng_n_q     <= '0;
      send_q      <= 1'b0;
      wd_q        <= '0;
      eng_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      eng_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
      // Abort outranks any completion or timeout seen in the same cycle.
      if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        state_q    <= S_ERR;
        err_code_q <= 2'd3;
        job_err_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_valid) begin
              eng_m_q    <= cmd_m;
              eng_k_q    <= cmd_k;
              eng_n_q    <= cmd_n;
              send_q     <= cmd_send;
              err_code_q <= 2'd0;
              state_q    <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (dims_bad) begin
              state_q    <= S_ERR;
              err_code_q <= 2'd1;
              job_err_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              wd_q    <= '0;
            end
          end
          S_LOAD: begin
            if (a_ready && b_ready) begin
              state_q     <= S_COMPUTE;
              eng_start_q <= 1'b1;
              wd_q        <= '0;
            end else if (wd_last) begin
              state_q    <= S_ERR;
              err_code_q <= 2'd2;
              job_err_q  <= 1'b1;
            end else begin
              wd_q <= wd_q + TW'(1);
            end
          end
          S_COMPUTE: begin
            // eng_done is not trusted during the start-pulse cycle.
            if (!eng_start_q && eng_done) begin
              if (send_q) begin
                state_q    <= S_SEND;
                tx_start_q <= 1'b1;
                wd_q       <= '0;
              end else begin
                state_q    <= S_DONE;
                job_done_q <= 1'b1;
              end
            end else if (wd_last) begin
              state_q    <= S_ERR;
              err_code_q <= 2'd2;
              job_err_q  <= 1'b1;
            end else begin
              wd_q <= wd_q + TW'(1);
            end
          end
          S_SEND: begin
            if (!tx_start_q && tx_done) begin
              state_q    <= S_DONE;
              job_done_q <= 1'b1;
            end else if (wd_last) begin
              state_q    <= S_ERR;
              err_code_q <= 2'd2;
              job_err_q  <= 1'b1;
            end else begin
              wd_q <= wd_q + TW'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign phase     = state_q;
  assign eng_start = eng_start_q;
  assign tx_start  = tx_start_q;
  assign job_done  = job_done_q;
  assign job_err   = job_err_q;
  assign err_code  = err_code_q;
  assign eng_m     = eng_m_q;
  assign eng_k     = eng_k_q;
  assign eng_n     = eng_n_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// tb/tb_matmul_job_sequencer.sv - bench for matmul_job_sequencer against a cycle-timeline job model.
`define CK(tg, o, e) chk(tg, 32'(o), 32'(e))
module tb_matmul_job_sequencer;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_send, abort, a_ready, b_ready;
  logic [10:0] cmd_m, eng_m;
  logic [9:0]  cmd_k, eng_k;
  logic [6:0]  cmd_n, eng_n;
  logic        eng_start, eng_done, tx_start, tx_done, busy, job_done, job_err;
  logic [1:0]  err_code;
  logic [2:0]  phase;

  always #5 clk = ~clk;

  matmul_job_sequencer #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_k(cmd_k), .cmd_n(cmd_n), .cmd_send(cmd_send),
    .abort(abort), .a_ready(a_ready), .b_ready(b_ready),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_m(eng_m), .eng_k(eng_k), .eng_n(eng_n),
    .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .job_done(job_done), .job_err(job_err), .err_code(err_code), .phase(phase)
  );

  int checks = 0;
  int errors = 0;
  int exp_seq[$];
  int obs_seq[$];
  int exp_end, exp_code;
  bit exp_eng, exp_tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int m, input int k, input int n, input bit send,
                       input int la, input int de, input int te, input int ab);
    int st[$];
    int en[$];
    int l, s, nx;
    bit bad;
    exp_code = 0;
    st.push_back(1); en.push_back(1);
    bad = (m == 0) || (k == 0) || (n == 0) || (m > 784) || (k > 288) || (n > 64);
    if (bad) begin
      st.push_back(6); en.push_back(2); exp_code = 1;
    end else begin
      st.push_back(2); en.push_back(2);
      l = (la > 2) ? la : 2;
      if (l - 2 <= T - 1) begin
        s = l + 1;
        st.push_back(3); en.push_back(s);
        if (de >= 1 && de <= T - 1) begin
          nx = s + de + 1;
          if (send) begin
            st.push_back(4); en.push_back(nx);
            if (te >= 1 && te <= T - 1) begin
              st.push_back(5); en.push_back(nx + te + 1);
            end else begin
              st.push_back(6); en.push_back(nx + T); exp_code = 2;
            end
          end else begin
            st.push_back(5); en.push_back(nx);
          end
        end else begin
          st.push_back(6); en.push_back(s + T); exp_code = 2;
        end
      end else begin
        st.push_back(6); en.push_back(2 + T); exp_code = 2;
      end
    end
    if (ab >= 1) begin
      while (en.size() > 0 && en[$] > ab) begin
        void'(st.pop_back());
        void'(en.pop_back());
      end
      st.push_back(6); en.push_back(ab + 1); exp_code = 3;
    end
    exp_end = en[$];
    exp_eng = 1'b0;
    exp_tx  = 1'b0;
    exp_seq.delete();
    foreach (st[i]) begin
      exp_seq.push_back(st[i]);
      if (st[i] == 3) exp_eng = 1'b1;
      if (st[i] == 4) exp_tx = 1'b1;
    end
    exp_seq.push_back(0);
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit send,
                         input int la_a, input int la_b, input int de, input int te,
                         input int ab, input bit stall);
    int es = -1;
    int xs = -1;
    int eng_cnt = 0;
    int tx_cnt = 0;
    int got = -1;
    bit fin = 1'b0;
    bit pd = 1'b0;
    bit pe = 1'b0;
    model(m, k, n, send, (la_a > la_b) ? la_a : la_b, de, te, ab);
    @(negedge clk);
    `CK("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_m = 11'(m); cmd_k = 10'(k); cmd_n = 7'(n); cmd_send = send;
    a_ready = 1'b0; b_ready = 1'b0; eng_done = 1'b0; tx_done = 1'b0; abort = 1'b0;
    obs_seq.delete();
    for (int t = 1; t <= 120 && !fin; t++) begin
      @(negedge clk);
      if (obs_seq.size() == 0 || obs_seq[$] != int'(phase)) obs_seq.push_back(int'(phase));
      if (eng_start) begin eng_cnt++; es = t; end
      if (tx_start) begin tx_cnt++; xs = t; end
      if (job_done || job_err) begin
        fin = 1'b1; got = t; pd = job_done; pe = job_err;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $error("FAIL busy_in_job observed %0d expected 1", busy);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $error("FAIL ready_while_busy observed %0d expected 0", cmd_ready);
        end
      end
      cmd_valid = stall && !fin;
      if (stall) begin
        cmd_m = 11'($urandom); cmd_k = 10'($urandom); cmd_n = 7'($urandom); cmd_send = 1'($urandom);
      end
      a_ready  = !fin && (t >= la_a);
      b_ready  = !fin && (t >= la_b);
      abort    = !fin && (t == ab);
      eng_done = !fin && (es >= 0) && (t == es + de);
      tx_done  = !fin && (xs >= 0) && (t == xs + te);
    end
    `CK("job_finished", fin, 1);
    checks++;
    if (got !== exp_end) begin
      errors++;
      $error("FAIL end_cycle observed %0d expected %0d", got, exp_end);
    end
    checks++;
    if (pd !== (exp_code == 0)) begin
      errors++;
      $error("FAIL job_done_pulse observed %0d expected %0d", pd, exp_code == 0);
    end
    checks++;
    if (pe !== (exp_code != 0)) begin
      errors++;
      $error("FAIL job_err_pulse observed %0d expected %0d", pe, exp_code != 0);
    end
    checks++;
    if (int'(err_code) !== exp_code) begin
      errors++;
      $error("FAIL err_code observed %0d expected %0d", err_code, exp_code);
    end
    `CK("eng_start_count", eng_cnt, exp_eng);
    `CK("tx_start_count", tx_cnt, exp_tx);
    `CK("eng_m", eng_m, m);
    `CK("eng_k", eng_k, k);
    `CK("eng_n", eng_n, n);
    @(negedge clk);
    if (obs_seq[$] != int'(phase)) obs_seq.push_back(int'(phase));
    `CK("idle_phase", phase, 0);
    `CK("idle_ready", cmd_ready, 1);
    `CK("err_code_held", err_code, exp_code);
    `CK("pulses_cleared", {job_done, job_err, eng_start, tx_start}, 0);
    `CK("phase_seq_len", obs_seq.size(), exp_seq.size());
    if (obs_seq.size() == exp_seq.size())
      foreach (exp_seq[i]) `CK("phase_seq", obs_seq[i], exp_seq[i]);
  endtask

  function automatic int rdim(input int mx);
    if ($urandom_range(0, 11) == 0)
      return ($urandom_range(0, 1) == 0) ? 0 : mx + int'($urandom_range(1, 3));
    return int'($urandom_range(1, mx));
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int m, k, n, la_a, la_b, de, te, ab, plan_end;
    bit send, seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_m = '0; cmd_k = '0; cmd_n = '0; cmd_send = 1'b0;
    abort = 1'b0; a_ready = 1'b0; b_ready = 1'b0; eng_done = 1'b0; tx_done = 1'b0;
    #3;
    `CK("rst_outputs", {cmd_ready, busy, phase, eng_start, tx_start, job_done, job_err, err_code}, 0);
    `CK("rst_dims", {eng_m, eng_k, eng_n}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    `CK("post_rst_phase", phase, 0);
    `CK("post_rst_ready", cmd_ready, 1);

    run_job(4, 3, 2, 1'b1, 5, 5, 10, 6, -1, 1'b0);
    run_job(4, 3, 2, 1'b0, 5, 5, 10, 6, -1, 1'b1);
    run_job(0, 3, 2, 1'b1, 1, 1, 3, 3, -1, 1'b0);
    run_job(4, 3, 65, 1'b1, 1, 1, 3, 3, -1, 1'b0);
    run_job(784, 288, 64, 1'b0, 1, 1, 2, 2, -1, 1'b0);
    run_job(785, 1, 1, 1'b0, 1, 1, 2, 2, -1, 1'b0);
    run_job(1, 289, 1, 1'b0, 1, 1, 2, 2, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 1, 1000, 3, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 17, 3, 3, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 18, 3, 3, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b0, 2, 2, T - 1, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b0, 2, 2, T - 1, 3, 18, 1'b0);
    run_job(5, 5, 5, 1'b0, 2, 2, T, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b0, 2, 2, 0, 3, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 2, 2, 2, T - 1, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 2, 2, 2, T, -1, 1'b0);
    run_job(5, 5, 5, 1'b1, 2, 2, 2, 0, -1, 1'b0);
    run_job(0, 5, 5, 1'b1, 2, 2, 2, 2, 1, 1'b0);
    run_job(5, 5, 5, 1'b1, 2, 2, 4, 9, 10, 1'b0);

    for (int i = 0; i < 30; i++) begin
      m = rdim(784); k = rdim(288); n = rdim(64);
      send = 1'($urandom);
      la_a = int'($urandom_range(1, 19)); la_b = int'($urandom_range(1, 19));
      de = int'($urandom_range(0, 18)); te = int'($urandom_range(0, 18));
      model(m, k, n, send, (la_a > la_b) ? la_a : la_b, de, te, -1);
      plan_end = exp_end;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, plan_end - 1)) : -1;
      run_job(m, k, n, send, la_a, la_b, de, te, ab, 1'($urandom));
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_m = 11'd5; cmd_k = 10'd7; cmd_n = 7'd9; cmd_send = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (phase == 3'd3) seen = 1'b1;
    end
    `CK("reach_compute", seen, 1);
    #2 rst = 1'b1;
    #1;
    `CK("async_rst_outputs", {cmd_ready, busy, phase, eng_start, tx_start, job_done, job_err, err_code}, 0);
    `CK("async_rst_dims", {eng_m, eng_k, eng_n}, 0);
    @(negedge clk); rst = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    `CK("rst_release_phase", phase, 0);
    `CK("rst_release_ready", cmd_ready, 1);
    run_job(4, 3, 2, 1'b1, 3, 4, 10, 6, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
